// File: rtl/serial_shift_pkg.sv
// Shared definitions for the serial shift controller: FSM encoding and default sizes.
package serial_shift_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DIV_WIDTH  = 8;
    localparam int DEFAULT_CNT_WIDTH  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

endpackage

// File: rtl/serial_shift_controller_if.sv
// Request/serial-side bundle of the serial shift controller.
interface serial_shift_controller_if
    import serial_shift_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) ();

    logic [DATA_WIDTH-1:0] data_in;
    logic [CNT_WIDTH-1:0]  bit_count;
    logic [DIV_WIDTH-1:0]  clk_div;
    logic                  valid;
    logic                  ready;
    logic                  sclk;
    logic                  sdo;
    logic                  cs_n;
    logic                  busy;
    logic                  done;

    modport master (
        output data_in, bit_count, clk_div, valid,
        input  ready, sclk, sdo, cs_n, busy, done
    );

    modport slave (
        input  data_in, bit_count, clk_div, valid,
        output ready, sclk, sdo, cs_n, busy, done
    );

endinterface

// File: rtl/shift_clk_div.sv
// Half-period timer: loads h, counts down, and ticks on the last cycle of each period.
module shift_clk_div #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] h,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= h;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    // A freshly loaded h occupies h cycles; the tick marks the final one.
    assign tick = (cnt == WIDTH'(1));

endmodule

// File: rtl/serial_shift_controller.sv
// Serial shift controller: frames a right-justified word out MSB first with a
// programmable half-period serial clock, chip select and done strobe.
module serial_shift_controller
    import serial_shift_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input logic                      clk,
    input logic                      rst,
    serial_shift_controller_if.slave bus
);

    localparam int HW = DIV_WIDTH + 1;

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_WIDTH-1:0]  bits_left;
    logic [HW-1:0]         h_q;
    logic                  ready_q, busy_q, sclk_q, sdo_q, cs_n_q, done_q;

    logic                  accept, tick, div_load;
    logic [CNT_WIDTH-1:0]  n_eff, shamt;
    logic [HW-1:0]         h_new, div_val;
    logic [DATA_WIDTH-1:0] aligned;

    // NOTE: every path assigns n_eff, so no latch is inferred for it.
    always_comb begin
        if (bus.bit_count == '0 || bus.bit_count > CNT_WIDTH'(DATA_WIDTH)) begin
            n_eff = CNT_WIDTH'(DATA_WIDTH);
        end else begin
            n_eff = bus.bit_count;
        end
    end

    // Left-align so bit N-1 lands in the MSB; zeros fill in behind the last bit.
    assign shamt    = CNT_WIDTH'(DATA_WIDTH) - n_eff;
    assign aligned  = bus.data_in << shamt;
    assign h_new    = {1'b0, bus.clk_div} + HW'(1);

    assign accept   = (state == IDLE) && ready_q && bus.valid;
    assign div_load = accept || (tick && state != IDLE);
    assign div_val  = accept ? h_new : h_q;

    shift_clk_div #(.WIDTH(HW)) u_div (
        .clk  (clk),
        .rst  (rst),
        .load (div_load),
        .h    (div_val),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is cleared with the control state so sdo never leaks stale data.
            state     <= IDLE;
            shreg     <= '0;
            bits_left <= '0;
            h_q       <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    if (accept) begin
                        state     <= SETUP;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        cs_n_q    <= 1'b0;
                        sclk_q    <= 1'b0;
                        sdo_q     <= aligned[DATA_WIDTH-1];
                        shreg     <= aligned;
                        bits_left <= n_eff;
                        h_q       <= h_new;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state  <= HIGH;
                        sclk_q <= 1'b1;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        state     <= LOW;
                        sclk_q    <= 1'b0;
                        shreg     <= shreg << 1;
                        sdo_q     <= shreg[DATA_WIDTH-2];
                        bits_left <= bits_left - CNT_WIDTH'(1);
                    end
                end
                LOW: begin
                    if (tick) begin
                        if (bits_left != '0) begin
                            state  <= HIGH;
                            sclk_q <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            cs_n_q  <= 1'b1;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            sdo_q   <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.sclk  = sclk_q;
    assign bus.sdo   = sdo_q;
    assign bus.cs_n  = cs_n_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_shift_controller.sv
// Self-checking bench for serial_shift_controller: vector table plus frame scoreboard.
module tb_serial_shift_controller;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  bc;
        logic [7:0]  div;
        bit          scramble;
        logic [31:0] exp_bits;
        int          exp_n;
        int          exp_cs;
    } vec_t;

    typedef struct {
        logic [31:0] bits;
        int          n;
        int          cs;
    } frame_t;

    logic clk;
    logic rst;

    serial_shift_controller_if #(.DATA_WIDTH(32), .DIV_WIDTH(8), .CNT_WIDTH(6)) bus ();

    serial_shift_controller #(.DATA_WIDTH(32), .DIV_WIDTH(8), .CNT_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    frame_t exp_q[$];
    vec_t   vecs[9];

    // Monitor state
    bit          in_frame = 1'b0;
    bit          prev_sclk = 1'b0;
    int          cs_cnt = 0;
    int          nb = 0;
    int          gap_cnt = 0;
    int          last_gap = 0;
    int          frames_seen = 0;
    int          done_total = 0;
    logic [31:0] acc = '0;
    frame_t      mf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame monitor: samples on the falling edge, scores each frame when cs_n rises.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
                nb       = 0;
                cs_cnt   = 0;
                gap_cnt  = 0;
            end else begin
                if (!bus.cs_n) begin
                    if (!in_frame) begin
                        in_frame = 1'b1;
                        cs_cnt   = 0;
                        nb       = 0;
                        acc      = '0;
                        last_gap = gap_cnt;
                    end
                    cs_cnt++;
                    if (bus.sclk && !prev_sclk) begin
                        acc = {acc[30:0], bus.sdo};
                        nb++;
                    end
                end else begin
                    gap_cnt = in_frame ? 0 : gap_cnt;
                    gap_cnt++;
                    if (in_frame) begin
                        in_frame = 1'b0;
                        if (exp_q.size() == 0) begin
                            check("frame_expected", 64'(exp_q.size()), 64'd1);
                        end else begin
                            mf = exp_q.pop_front();
                            check("frame_bits", 64'(acc), 64'(mf.bits));
                            check("frame_nbits", 64'(nb), 64'(mf.n));
                            check("cs_low_cycles", 64'(cs_cnt), 64'(mf.cs));
                            check("done_at_end", 64'(bus.done), 64'd1);
                            check("sdo_after_last", 64'(bus.sdo), 64'd0);
                        end
                        frames_seen++;
                        nb = 0;
                    end
                end
                if (bus.done) done_total++;
            end
            prev_sclk = bus.sclk;
        end
    end

    task automatic send(input vec_t v, input bit push);
        int     t;
        frame_t f;
        t = 0;
        while (!bus.ready && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("ready_wait", 64'(bus.ready), 64'd1);
        bus.data_in   = v.data;
        bus.bit_count = v.bc;
        bus.clk_div   = v.div;
        bus.valid     = 1'b1;
        if (push) begin
            f.bits = v.exp_bits;
            f.n    = v.exp_n;
            f.cs   = v.exp_cs;
            exp_q.push_back(f);
        end
        @(posedge clk); #1;
        bus.valid = 1'b0;
        if (v.scramble) begin
            bus.data_in   = $urandom;
            bus.bit_count = 6'($urandom);
            bus.clk_div   = 8'($urandom);
        end
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (frames_seen < target && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("frame_complete", 64'(frames_seen >= target), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dtot;
        int t;

        //           data          bc     div   scr   exp_bits      n   cs
        vecs[0] = '{32'h000000A5, 6'd8,  8'd1, 1'b0, 32'h000000A5, 8,  34};
        vecs[1] = '{32'h80000001, 6'd0,  8'd0, 1'b0, 32'h80000001, 32, 65};
        vecs[2] = '{32'h80000001, 6'd40, 8'd0, 1'b0, 32'h80000001, 32, 65};
        vecs[3] = '{32'h12345678, 6'd4,  8'd2, 1'b1, 32'h00000008, 4,  27};
        vecs[4] = '{32'hFFFFFFFF, 6'd1,  8'd0, 1'b1, 32'h00000001, 1,  3};
        vecs[5] = '{32'h00000003, 6'd32, 8'd3, 1'b1, 32'h00000003, 32, 260};
        vecs[6] = '{32'hDEADBEEF, 6'd16, 8'd0, 1'b1, 32'h0000BEEF, 16, 33};
        vecs[7] = '{32'h00000000, 6'd33, 8'd0, 1'b0, 32'h00000000, 32, 65};
        vecs[8] = '{32'h00000155, 6'd9,  8'd4, 1'b1, 32'h00000155, 9,  95};

        rst           = 1'b1;
        bus.valid     = 1'b0;
        bus.data_in   = '0;
        bus.bit_count = '0;
        bus.clk_div   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.ready), 64'd0);
        check("rst_busy",  64'(bus.busy),  64'd0);
        check("rst_sclk",  64'(bus.sclk),  64'd0);
        check("rst_sdo",   64'(bus.sdo),   64'd0);
        check("rst_cs_n",  64'(bus.cs_n),  64'd1);
        check("rst_done",  64'(bus.done),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(bus.ready), 64'd1);
        check("busy_after_reset",  64'(bus.busy),  64'd0);

        for (int i = 0; i < 9; i++) begin
            base = frames_seen;
            send(vecs[i], 1'b1);
            wait_frames(base + 1);
        end

        // Back-to-back: valid held high across the done cycle.
        base = frames_seen;
        dtot = done_total;
        bus.data_in   = 32'h000000A5;
        bus.bit_count = 6'd8;
        bus.clk_div   = 8'd0;
        bus.valid     = 1'b1;
        exp_q.push_back('{32'h000000A5, 8, 17});
        exp_q.push_back('{32'h000000A5, 8, 17});
        wait_frames(base + 1);
        bus.valid = 1'b0;
        wait_frames(base + 2);
        check("b2b_cs_gap", 64'(last_gap), 64'd1);
        check("b2b_done_count", 64'(done_total - dtot), 64'd2);

        // valid pulsed while busy must not start a queued frame.
        base = frames_seen;
        send(vecs[0], 1'b1);
        repeat (5) @(posedge clk);
        #1;
        bus.valid   = 1'b1;
        bus.data_in = 32'h0000003C;
        repeat (3) @(posedge clk);
        #1;
        bus.valid = 1'b0;
        wait_frames(base + 1);
        repeat (60) @(posedge clk);
        #1;
        check("busy_valid_ignored", 64'(frames_seen), 64'(base + 1));
        check("idle_busy", 64'(bus.busy), 64'd0);

        // Reset at the third sclk rise aborts the frame without done.
        send(vecs[0], 1'b0);
        t = 0;
        while (nb < 3 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("third_rise_seen", 64'(nb >= 3), 64'd1);
        dtot = done_total;
        rst  = 1'b1;
        @(posedge clk); #1;
        check("abort_cs_n",  64'(bus.cs_n),  64'd1);
        check("abort_sclk",  64'(bus.sclk),  64'd0);
        check("abort_done",  64'(bus.done),  64'd0);
        check("abort_ready", 64'(bus.ready), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready_after", 64'(bus.ready), 64'd1);
        check("abort_busy_after",  64'(bus.busy),  64'd0);
        check("abort_no_done", 64'(done_total), 64'(dtot));

        // Normal frame after the abort.
        base = frames_seen;
        send(vecs[6], 1'b1);
        wait_frames(base + 1);

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("done_per_frame", 64'(done_total), 64'(frames_seen));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
